// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_unit
//  Purpose  : ID/EX operand-forwarding select generation and load-use stall
//             control with a saturating stall-cycle counter.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_hazard_unit #(
   parameter int  NREAD    = 2,
   parameter int  NSTAGE   = 3,
   parameter int  REGW     = 5,
   parameter int  LOAD_LAT = 1,
   parameter int  CNTW     = 16,
   localparam int SELW     = $clog2(NSTAGE + 2)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   id_valid,
   input  logic [NREAD*REGW-1:0]  id_rs,
   input  logic [NREAD-1:0]       id_use,
   input  logic [NREAD-1:0]       id_imm_sel,
   input  logic [NSTAGE*REGW-1:0] src_rd,
   input  logic [NSTAGE-1:0]      src_wen,
   input  logic [NSTAGE-1:0]      src_isload,
   input  logic                   flush,
   input  logic                   clr_cnt,
   output logic [NREAD*SELW-1:0]  fwd_sel,
   output logic                   stall,
   output logic                   bubble,
   output logic [CNTW-1:0]        stall_cnt
);

   localparam logic [SELW-1:0] C_SEL_IMM = '1;
   localparam logic [CNTW-1:0] C_CNT_MAX = '1;

   logic [NREAD-1:0]      w_hit;
   logic [NREAD-1:0]      w_hit_load;
   logic [SELW-1:0]       w_hit_sel [NREAD];
   logic [NREAD*SELW-1:0] w_next_sel;
   logic                  w_hazard;
   logic                  w_squash;

   logic [NREAD*SELW-1:0] r_fwd_sel;
   logic                  r_bubble;
   logic [CNTW-1:0]       r_stall_cnt;

   // Scan oldest to youngest so the youngest matching stage is the one kept.
   always_comb begin : p_match
      for (int i = 0; i < NREAD; i++) begin
         w_hit[i]      = 1'b0;
         w_hit_load[i] = 1'b0;
         w_hit_sel[i]  = '0;
         for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (src_wen[k] &&
                (src_rd[k*REGW +: REGW] == id_rs[i*REGW +: REGW]) &&
                (id_rs[i*REGW +: REGW] != '0)) begin
               w_hit[i]      = 1'b1;
               w_hit_sel[i]  = SELW'(k + 1);
               w_hit_load[i] = src_isload[k] && (k < LOAD_LAT);
            end
         end
      end
   end

   always_comb begin : p_select
      w_hazard   = 1'b0;
      w_next_sel = '0;
      for (int i = 0; i < NREAD; i++) begin
         if (id_imm_sel[i]) begin
            w_next_sel[i*SELW +: SELW] = C_SEL_IMM;
         end else if (id_use[i] && w_hit[i]) begin
            w_next_sel[i*SELW +: SELW] = w_hit_sel[i];
         end
         if (id_valid && id_use[i] && !id_imm_sel[i] && w_hit_load[i]) begin
            w_hazard = 1'b1;
         end
      end
   end

   // Gated by rstn so the stall drops the instant reset is asserted.
   assign stall    = rstn & w_hazard & ~flush;
   assign w_squash = flush | stall | ~id_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_fwd_sel   <= '0;
         r_bubble    <= 1'b1;
         r_stall_cnt <= '0;
      end else begin
         if (w_squash) begin
            r_fwd_sel <= '0;
            r_bubble  <= 1'b1;
         end else begin
            r_fwd_sel <= w_next_sel;
            r_bubble  <= 1'b0;
         end
         if (clr_cnt) begin
            r_stall_cnt <= '0;
         end else if (stall && (r_stall_cnt != C_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNTW'(1);
         end
      end
   end

   assign fwd_sel   = r_fwd_sel;
   assign bubble    = r_bubble;
   assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwd_hazard_unit
//  Purpose  : Directed and randomized checks of fwd_hazard_unit; two
//             instances (default and LOAD_LAT=2/CNTW=4) share the stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_unit;

   logic        clk;
   logic        rstn;
   logic        id_valid;
   logic [9:0]  id_rs;
   logic [1:0]  id_use;
   logic [1:0]  id_imm_sel;
   logic [14:0] src_rd;
   logic [2:0]  src_wen;
   logic [2:0]  src_isload;
   logic        flush;
   logic        clr_cnt;

   logic [5:0]  fwd_sel_a, fwd_sel_b;
   logic        stall_a, stall_b;
   logic        bubble_a, bubble_b;
   logic [15:0] stall_cnt_a;
   logic [3:0]  stall_cnt_b;

   int checks = 0;
   int errors = 0;

   // Reference model state, index 0 = default instance, 1 = LOAD_LAT=2/CNTW=4
   int         c_ll [2]  = '{1, 2};
   int         c_max [2] = '{65535, 15};
   logic [5:0] m_sel [2];
   logic       m_bub [2];
   int         m_cnt [2];
   logic       m_stall [2];
   logic [5:0] m_nsel [2];

   fwd_hazard_unit dut_a (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs),
      .id_use(id_use), .id_imm_sel(id_imm_sel), .src_rd(src_rd),
      .src_wen(src_wen), .src_isload(src_isload), .flush(flush),
      .clr_cnt(clr_cnt), .fwd_sel(fwd_sel_a), .stall(stall_a),
      .bubble(bubble_a), .stall_cnt(stall_cnt_a)
   );

   fwd_hazard_unit #(.LOAD_LAT(2), .CNTW(4)) dut_b (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs),
      .id_use(id_use), .id_imm_sel(id_imm_sel), .src_rd(src_rd),
      .src_wen(src_wen), .src_isload(src_isload), .flush(flush),
      .clr_cnt(clr_cnt), .fwd_sel(fwd_sel_b), .stall(stall_b),
      .bubble(bubble_b), .stall_cnt(stall_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      id_valid = 0; id_rs = '0; id_use = '0; id_imm_sel = '0;
      src_rd = '0; src_wen = '0; src_isload = '0; flush = 0; clr_cnt = 0;
   endtask

   task automatic model_reset();
      for (int j = 0; j < 2; j++) begin
         m_sel[j] = '0; m_bub[j] = 1'b1; m_cnt[j] = 0; m_stall[j] = 1'b0;
      end
   endtask

   // Youngest writer of each source decides both the select and the hazard.
   task automatic model_comb(input int ll, output logic [5:0] sel, output logic haz);
      haz = 1'b0;
      sel = '0;
      for (int i = 0; i < 2; i++) begin
         logic [4:0] rs;
         int         y;
         rs = id_rs[i*5 +: 5];
         y  = -1;
         for (int k = 0; k < 3; k++)
            if (y < 0 && src_wen[k] && src_rd[k*5 +: 5] == rs && rs != 0) y = k;
         if (id_imm_sel[i])              sel[i*3 +: 3] = 3'd7;
         else if (id_use[i] && y >= 0)   sel[i*3 +: 3] = 3'(y + 1);
         if (id_valid && id_use[i] && !id_imm_sel[i] && y >= 0 && y < ll && src_isload[y])
            haz = 1'b1;
      end
   endtask

   task automatic eval();
      logic h;
      for (int j = 0; j < 2; j++) begin
         model_comb(c_ll[j], m_nsel[j], h);
         m_stall[j] = h && !flush && rstn;
      end
   endtask

   task automatic settle();
      #2;
      eval();
   endtask

   task automatic tick();
      eval();
      @(posedge clk);
      for (int j = 0; j < 2; j++) begin
         if (flush || m_stall[j] || !id_valid) begin
            m_sel[j] = '0; m_bub[j] = 1'b1;
         end else begin
            m_sel[j] = m_nsel[j]; m_bub[j] = 1'b0;
         end
         if (clr_cnt)                                m_cnt[j] = 0;
         else if (m_stall[j] && m_cnt[j] < c_max[j]) m_cnt[j]++;
      end
      #1;
   endtask

   task automatic test_reset();
      rstn = 0;
      clear_inputs();
      model_reset();
      id_valid = 1; id_use = 2'b01; id_rs[4:0] = 5'd9;
      src_rd[4:0] = 5'd9; src_wen = 3'b001; src_isload = 3'b001;
      #12;
      checks++; if (stall_a !== 1'b0)    begin errors++; $display("FAIL reset_stall: got %b want 0", stall_a); end
      checks++; if (bubble_a !== 1'b1)   begin errors++; $display("FAIL reset_bubble: got %b want 1", bubble_a); end
      checks++; if (fwd_sel_a !== 6'd0)  begin errors++; $display("FAIL reset_fwd_sel: got %h want 0", fwd_sel_a); end
      checks++; if (stall_cnt_a !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt_a); end
      clear_inputs();
      @(negedge clk);
      rstn = 1;
      tick();
      checks++; if (bubble_a !== 1'b1)   begin errors++; $display("FAIL post_reset_bubble: got %b want 1", bubble_a); end
   endtask

   task automatic test_forward_basic();
      clear_inputs();
      id_valid = 1; id_use = 2'b11; id_rs[4:0] = 5'd5; src_rd[4:0] = 5'd5; src_wen = 3'b001;
      settle();
      checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL fwd_basic_stall: got %b want 0", stall_a); end
      tick();
      checks++; if (fwd_sel_a[2:0] !== 3'd1) begin errors++; $display("FAIL fwd_basic_sel0: got %0d want 1", fwd_sel_a[2:0]); end
      checks++; if (bubble_a !== 1'b0) begin errors++; $display("FAIL fwd_basic_bubble: got %b want 0", bubble_a); end
      id_rs[4:0] = 5'd0; src_rd[4:0] = 5'd0;
      tick();
      checks++; if (fwd_sel_a[2:0] !== 3'd0) begin errors++; $display("FAIL fwd_x0_sel0: got %0d want 0", fwd_sel_a[2:0]); end
   endtask

   task automatic test_priority();
      clear_inputs();
      id_valid = 1; id_use = 2'b11; id_rs[9:5] = 5'd7;
      src_rd[9:5] = 5'd7; src_rd[14:10] = 5'd7; src_wen = 3'b110;
      tick();
      checks++; if (fwd_sel_a[5:3] !== 3'd2) begin errors++; $display("FAIL prio_youngest: got %0d want 2", fwd_sel_a[5:3]); end
      id_imm_sel = 2'b10;
      tick();
      checks++; if (fwd_sel_a[5:3] !== 3'd7) begin errors++; $display("FAIL prio_imm: got %0d want 7", fwd_sel_a[5:3]); end
   endtask

   task automatic test_load_use();
      int cnt0;
      clear_inputs();
      id_valid = 1; id_use = 2'b01; id_rs[4:0] = 5'd9;
      src_rd[4:0] = 5'd9; src_wen = 3'b001; src_isload = 3'b001;
      cnt0 = m_cnt[0];
      settle();
      checks++; if (stall_a !== 1'b1) begin errors++; $display("FAIL load_stall: got %b want 1", stall_a); end
      tick();
      checks++; if (bubble_a !== 1'b1 || fwd_sel_a !== 6'd0) begin errors++; $display("FAIL load_bubble: got bubble %b sel %h want 1/0", bubble_a, fwd_sel_a); end
      checks++; if (stall_cnt_a !== 16'(cnt0 + 1)) begin errors++; $display("FAIL load_cnt: got %0d want %0d", stall_cnt_a, cnt0 + 1); end
      src_rd = '0; src_rd[9:5] = 5'd9; src_wen = 3'b010; src_isload = 3'b010;
      settle();
      checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL load_adv_stall: got %b want 0", stall_a); end
      tick();
      checks++; if (fwd_sel_a[2:0] !== 3'd2 || bubble_a !== 1'b0) begin errors++; $display("FAIL load_adv_sel: got sel %0d bubble %b want 2/0", fwd_sel_a[2:0], bubble_a); end
      src_rd = '0; src_rd[4:0] = 5'd9; src_wen = 3'b001; src_isload = 3'b001; id_use = 2'b00;
      settle();
      checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL load_unused: got %b want 0", stall_a); end
      tick();
   endtask

   task automatic test_load_lat2();
      clear_inputs();
      clr_cnt = 1;
      tick();
      clr_cnt = 0;
      id_valid = 1; id_use = 2'b10; id_rs[9:5] = 5'd3;
      src_rd[4:0] = 5'd3; src_wen = 3'b001; src_isload = 3'b001;
      settle();
      checks++; if (stall_b !== 1'b1) begin errors++; $display("FAIL lat2_stall_s0: got %b want 1", stall_b); end
      tick();
      src_rd = '0; src_rd[9:5] = 5'd3; src_wen = 3'b010; src_isload = 3'b010;
      settle();
      checks++; if (stall_b !== 1'b1) begin errors++; $display("FAIL lat2_stall_s1: got %b want 1", stall_b); end
      tick();
      src_rd = '0; src_rd[14:10] = 5'd3; src_wen = 3'b100; src_isload = 3'b100;
      settle();
      checks++; if (stall_b !== 1'b0) begin errors++; $display("FAIL lat2_stall_s2: got %b want 0", stall_b); end
      tick();
      checks++; if (stall_cnt_b !== 4'd2) begin errors++; $display("FAIL lat2_cnt: got %0d want 2", stall_cnt_b); end
      checks++; if (fwd_sel_b[5:3] !== 3'd3 || bubble_b !== 1'b0) begin errors++; $display("FAIL lat2_sel: got sel %0d bubble %b want 3/0", fwd_sel_b[5:3], bubble_b); end
   endtask

   task automatic test_flush();
      int cnt0;
      clear_inputs();
      id_valid = 1; id_use = 2'b01; id_rs[4:0] = 5'd9;
      src_rd[4:0] = 5'd9; src_wen = 3'b001; src_isload = 3'b001; flush = 1;
      cnt0 = m_cnt[0];
      settle();
      checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall_a); end
      tick();
      checks++; if (bubble_a !== 1'b1) begin errors++; $display("FAIL flush_bubble: got %b want 1", bubble_a); end
      checks++; if (stall_cnt_a !== 16'(cnt0)) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt_a, cnt0); end
   endtask

   task automatic test_saturate_and_reset();
      clear_inputs();
      id_valid = 1; id_use = 2'b10; id_rs[9:5] = 5'd3;
      src_rd[4:0] = 5'd3; src_wen = 3'b001; src_isload = 3'b001;
      for (int n = 0; n < 20; n++) tick();
      checks++; if (stall_cnt_b !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d want 15", stall_cnt_b); end
      clr_cnt = 1;
      settle();
      checks++; if (stall_b !== 1'b1) begin errors++; $display("FAIL clr_stall: got %b want 1", stall_b); end
      tick();
      checks++; if (stall_cnt_b !== 4'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", stall_cnt_b); end
      clr_cnt = 0;
      tick();
      #2;
      rstn = 0;
      #1;
      checks++; if (stall_b !== 1'b0 || stall_a !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b/%b want 0/0", stall_a, stall_b); end
      checks++; if (bubble_b !== 1'b1 || fwd_sel_b !== 6'd0 || stall_cnt_b !== 4'd0) begin errors++; $display("FAIL midrst_regs: got bubble %b sel %h cnt %0d want 1/0/0", bubble_b, fwd_sel_b, stall_cnt_b); end
      clear_inputs();
      model_reset();
      @(negedge clk);
      rstn = 1;
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         id_valid   = ($urandom_range(0, 7) != 0);
         id_rs      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         id_use     = 2'($urandom);
         id_imm_sel = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         src_rd     = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         src_wen    = 3'($urandom);
         src_isload = 3'($urandom);
         flush      = ($urandom_range(0, 9) == 0);
         clr_cnt    = ($urandom_range(0, 19) == 0);
         settle();
         checks++; if (stall_a !== m_stall[0]) begin errors++; $display("FAIL rand_stall_a cyc %0d: got %b want %b", n, stall_a, m_stall[0]); end
         checks++; if (stall_b !== m_stall[1]) begin errors++; $display("FAIL rand_stall_b cyc %0d: got %b want %b", n, stall_b, m_stall[1]); end
         tick();
         checks++; if (fwd_sel_a !== m_sel[0] || bubble_a !== m_bub[0]) begin errors++; $display("FAIL rand_regs_a cyc %0d: got sel %h bubble %b want %h/%b", n, fwd_sel_a, bubble_a, m_sel[0], m_bub[0]); end
         checks++; if (fwd_sel_b !== m_sel[1] || bubble_b !== m_bub[1]) begin errors++; $display("FAIL rand_regs_b cyc %0d: got sel %h bubble %b want %h/%b", n, fwd_sel_b, bubble_b, m_sel[1], m_bub[1]); end
         checks++; if (stall_cnt_a !== 16'(m_cnt[0]) || stall_cnt_b !== 4'(m_cnt[1])) begin errors++; $display("FAIL rand_cnt cyc %0d: got %0d/%0d want %0d/%0d", n, stall_cnt_a, stall_cnt_b, m_cnt[0], m_cnt[1]); end
      end
   endtask

   initial begin
      test_reset();
      test_forward_basic();
      test_priority();
      test_load_use();
      test_load_lat2();
      test_flush();
      test_saturate_and_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and load-use hazard controller for the pipelined RISC-V core. It sits beside the ID/EX boundary. Each cycle it compares the decode-stage source registers against the destination registers of every downstream pipeline stage. It then registers one forwarding select per read port for use by the EX-stage operand muxes. It also stalls fetch/decode and injects an EX bubble when a load result is not yet forwardable, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- NREAD, 2: number of register read ports (operands) per instruction
- NSTAGE, 3: number of forwarding sources; stage 0 is youngest (EX/MEM), NSTAGE-1 oldest (WB)
- REGW, 5: register index width
- LOAD_LAT, 1: load data is forwardable only from stage index >= LOAD_LAT; range 1..NSTAGE-1
- CNTW, 16: stall counter width
- SELW (derived): clog2(NSTAGE+2); not overridden

Ports (clock and reset):
- clk  in  1  single clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low

Other ports:
- id_valid  in  1  decode stage holds a valid instruction
- id_rs  in  NREAD*REGW  source register indices; port i at bits [i*REGW +: REGW]
- id_use  in  NREAD  port i actually reads a register
- id_imm_sel  in  NREAD  port i takes the immediate instead of a register
- src_rd  in  NSTAGE*REGW  destination index of stage k at [k*REGW +: REGW]
- src_wen  in  NSTAGE  stage k will write src_rd[k]
- src_isload  in  NSTAGE  stage k holds a load
- flush  in  1  pipeline flush (branch/jump redirect)
- clr_cnt  in  1  synchronous clear of stall_cnt
- fwd_sel  out  NREAD*SELW  registered select per port; 0 = register file, k+1 = stage k, all-ones = immediate
- stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble  out  1  registered; EX holds a NOP this cycle
- stall_cnt  out  CNTW  saturating count of stalled cycles

## Operation
- Per port i, a match is stage k with src_wen[k], src_rd[k]==id_rs[i], and id_rs[i]!=0. Only the lowest k (youngest) is considered.
- Per-port selection priority:
  - id_imm_sel[i]=1 → all-ones
  - youngest match k → k+1
  - otherwise → 0
  - id_use[i]=0 and id_imm_sel[i]=0 → 0
- hazard = id_valid and, for some port i with id_use[i]=1 and id_imm_sel[i]=0, the youngest match k has src_isload[k]=1 and k < LOAD_LAT. An older matching stage never masks a younger load.
- stall = hazard and not flush. It is forced to 0 while rstn is low.
- Next-state update on each rising edge:
  - if flush or stall or not id_valid: fwd_sel <= 0 on all ports, bubble <= 1
  - else: fwd_sel <= computed selects, bubble <= 0
- During a stall, the ID inputs remain constant and re-evaluation occurs each cycle. The stall lasts exactly LOAD_LAT - k cycles for a load first seen at stage k. No explicit FSM state is kept beyond the registers.
- stall_cnt increments by 1 on each edge where stall=1 and saturates at 2^CNTW-1. clr_cnt has priority over increment and loads 0.

## Timing
- Reset values while rstn is low: fwd_sel=0, bubble=1, stall_cnt=0, stall=0.
- Reset asserted mid-stall clears all outputs immediately. The first post-reset edge evaluates normally.
- Latency: fwd_sel and bubble reflect the ID inputs of the previous cycle. stall has zero latency (same cycle).
- Simultaneous events:
  - flush and hazard together: flush wins; no stall, no counter increment
  - clr_cnt and stall together: counter becomes 0

## Test plan
- Defaults; rs0=5, src_rd[0]=5, src_wen[0]=1, not a load → no stall; next cycle fwd_sel[0]=1. Repeat with rs0=0 and src_rd[0]=0 → fwd_sel[0]=0.
- rs1=7; stages 1 and 2 both write 7 → fwd_sel[1]=2. Set id_imm_sel[1]=1 → fwd_sel[1]=7.
- Load at stage 0 with rd=9; rs0=9 → stall=1 that cycle, next bubble=1 and fwd_sel=0. Advance the load to stage 1 → stall=0, then fwd_sel[0]=2 and bubble=0. Load at stage 0 with rd=9 and id_use[0]=0 → no stall.
- LOAD_LAT=2; load at stage 0 with rd=3; rs1=3 → stall held for 2 cycles (stall_cnt=2), then fwd_sel[1]=3.
- Hazard with flush=1 in the same cycle → stall=0, next bubble=1, stall_cnt unchanged.
- CNTW=4; hold a hazard for 20 cycles → stall_cnt=15. Pulse clr_cnt → 0. Drop rstn mid-stall → stall=0, bubble=1, fwd_sel=0 immediately.
